mmm_modadd_sched: RTL and testbench

MMM_MODADD_SCHED -- requirements
Module: mmm_modadd_sched

---
 rtl/mmm_modadd_pkg.sv | 23 ++
 rtl/mmm_modadd_sched_if.sv | 37 +++
 rtl/mmm_rr_arb.sv | 34 +++
 rtl/mmm_modadd_sched.sv | 150 +++++++++++++++
 tb/tb_mmm_modadd_sched.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmm_modadd_pkg.sv
// mmm_modadd_pkg
// Shared definitions for the modular add/sub scheduler: FSM state encoding,
// engine op encodings, the default engine timeout and a helper that sizes
// requester-id fields so a single-requester build still has a 1-bit id.
package mmm_modadd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int TIMEOUT_DEFAULT = 1024;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmm_modadd_sched_if.sv
// mmm_modadd_sched_if
// Requester and response bus of the modular add/sub scheduler.
//   i_req_valid/o_req_ready : per-requester handshake (ready one-hot or zero)
//   i_req_op/i_req_mode     : per-requester op (1 add, 0 sub) and engine mode
//   i_req_a/i_req_b         : operands, requester k at [k*WIDTH +: WIDTH]
//   o_rsp_valid/i_rsp_ready : response handshake
//   o_rsp_id/o_rsp_c/o_rsp_err : requester id, result, timeout flag
// master = requester side, slave = scheduler side.
interface mmm_modadd_sched_if #(
  parameter int WIDTH = 260,
  parameter int NREQ  = 4
);
  localparam int IDW = mmm_modadd_pkg::id_width(NREQ);

  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ-1:0]       i_req_op;
  logic [NREQ-1:0]       i_req_mode;
  logic [NREQ*WIDTH-1:0] i_req_a;
  logic [NREQ*WIDTH-1:0] i_req_b;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [IDW-1:0]        o_rsp_id;
  logic [WIDTH-1:0]      o_rsp_c;
  logic                  o_rsp_err;

  modport master (
    output i_req_valid, i_req_op, i_req_mode, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_c, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_mode, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_c, o_rsp_err
  );

endinterface

// File: rtl/mmm_rr_arb.sv
// mmm_rr_arb
// Round-robin one-hot grant. The search starts at (last_grant+1) mod NREQ and
// wraps, so the most recently served requester has lowest priority.
//   req        : request vector
//   last_grant : index of the previously accepted requester
//   grant      : one-hot grant, zero when no request is pending
module mmm_rr_arb
  import mmm_modadd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmm_modadd_sched.sv
// mmm_modadd_sched
// Shares one modular add/sub engine between NREQ requesters. A request is
// granted round-robin in IDLE, its operands are latched and presented to the
// engine during RUN, the result (or a timeout abort) is offered on the
// response bus in RESP, and DRAIN waits for the engine flag to drop.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus           : requester/response bus (slave modport)
//   i_p           : shared modulus, forwarded to the engine as o_eng_p
//   o_eng_en      : engine enable, high for the whole of RUN
//   o_eng_mode/a/b: latched engine operands
//   i_eng_c/flag  : engine result and result-valid
//   o_busy        : high whenever the FSM is not idle
module mmm_modadd_sched
  import mmm_modadd_pkg::*;
#(
  parameter int WIDTH   = 260,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  mmm_modadd_sched_if.slave       bus,
  input  logic [WIDTH-1:0]        i_p,
  output logic                    o_eng_en,
  output logic                    o_eng_mode,
  output logic [WIDTH-1:0]        o_eng_a,
  output logic [WIDTH-1:0]        o_eng_b,
  output logic [WIDTH-1:0]        o_eng_p,
  input  logic [WIDTH-1:0]        i_eng_c,
  input  logic                    i_eng_flag,
  output logic                    o_busy
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  lat_id;
  logic            op_q;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [IDW-1:0]  gidx;
  logic            accept;
  logic            timeout_hit;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic            sel_op;
  logic            sel_mode;

  mmm_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (bus.i_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grants are only offered while idle, so ready is zero everywhere else.
  assign ready           = grant & {NREQ{state == IDLE}};
  assign bus.o_req_ready = ready;
  assign accept          = |(ready & bus.i_req_valid);

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) gidx = IDW'(k);
    end
  end

  assign sel_a       = bus.i_req_a[int'(gidx)*WIDTH +: WIDTH];
  assign sel_b       = bus.i_req_b[int'(gidx)*WIDTH +: WIDTH];
  assign sel_op      = bus.i_req_op[gidx];
  assign sel_mode    = bus.i_req_mode[gidx];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  assign o_eng_p = i_p;
  assign o_busy  = (state != IDLE);

  // The engine enable is "op OR 1": the engine treats it as start+select, so
  // it is high for every RUN cycle regardless of add/sub. On exit from RUN an
  // engine flag takes priority over a coinciding timeout.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= IDLE;
      last_grant      <= IDW'(NREQ - 1);
      lat_id          <= '0;
      op_q            <= OP_SUB;
      cnt             <= '0;
      o_eng_en        <= 1'b0;
      o_eng_mode      <= 1'b0;
      o_eng_a         <= '0;
      o_eng_b         <= '0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_id    <= '0;
      bus.o_rsp_c     <= '0;
      bus.o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_id     <= gidx;
            last_grant <= gidx;
            op_q       <= sel_op;
            o_eng_mode <= sel_mode;
            o_eng_a    <= sel_a;
            o_eng_b    <= sel_b;
            cnt        <= '0;
            o_eng_en   <= sel_op | 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (i_eng_flag) begin
            bus.o_rsp_c     <= i_eng_c;
            bus.o_rsp_err   <= 1'b0;
            bus.o_rsp_id    <= lat_id;
            bus.o_rsp_valid <= 1'b1;
            o_eng_en        <= 1'b0;
            state           <= RESP;
          end else if (timeout_hit) begin
            bus.o_rsp_c     <= '0;
            bus.o_rsp_err   <= 1'b1;
            bus.o_rsp_id    <= lat_id;
            bus.o_rsp_valid <= 1'b1;
            o_eng_en        <= 1'b0;
            state           <= RESP;
          end else begin
            o_eng_en <= op_q | 1'b1;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            bus.o_rsp_valid <= 1'b0;
            state           <= DRAIN;
          end
        end
        DRAIN: begin
          if (!i_eng_flag) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_modadd_sched.sv
// tb_mmm_modadd_sched
// Self-checking bench: behavioural engine with programmable flag latency,
// table of single-request vectors, plus hand sequences for round-robin,
// backpressure and reset during RUN. Expected responses go into a queue when
// stimulus is driven and are compared when the DUT hands a response over.
module tb_mmm_modadd_sched;
  import mmm_modadd_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;
  localparam int P       = 13;

  typedef struct {
    int          id;
    logic        op;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] c;
    logic        err;
    int          en_cyc;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] c;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mmm_modadd_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

  logic [WIDTH-1:0] p_val;
  logic             eng_en, eng_mode, eng_flag, busy;
  logic [WIDTH-1:0] eng_a, eng_b, eng_p, eng_c;

  mmm_modadd_sched #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .bus        (bus),
    .i_p        (p_val),
    .o_eng_en   (eng_en),
    .o_eng_mode (eng_mode),
    .o_eng_a    (eng_a),
    .o_eng_b    (eng_b),
    .o_eng_p    (eng_p),
    .i_eng_c    (eng_c),
    .i_eng_flag (eng_flag),
    .o_busy     (busy)
  );

  int checks = 0;
  int passes = 0;
  exp_t expq[$];

  // engine model: flag on the lat-th enabled cycle, lat=0 never flags
  int   lat = 1;
  logic cur_op = 1'b1;
  int   eng_cnt;

  function automatic logic [15:0] modp(input logic [15:0] a, input logic [15:0] b, input logic op);
    int s;
    if (op) s = (int'(a) + int'(b)) % P;
    else    s = (int'(a) + P - int'(b)) % P;
    return 16'(s);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) eng_cnt <= 0;
    else       eng_cnt <= eng_en ? eng_cnt + 1 : 0;
  end

  always_comb begin
    eng_flag = eng_en && (lat > 0) && (eng_cnt == lat - 1);
    eng_c    = eng_flag ? modp(eng_a, eng_b, cur_op) : 16'hBEEF;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt = 0, rsp_cnt = 0;
  int acc_cyc, rsp_cyc, en_cyc;
  bit en_seen, rsp_seen;
  logic seen_mode;
  logic [15:0] seen_a, seen_b;

  always @(negedge clk) begin
    if (rstn) begin
      if (|(bus.o_req_ready & bus.i_req_valid)) begin
        acc_cnt++;
        acc_cyc  = cyc;
        en_cyc   = 0;
        en_seen  = 0;
        rsp_seen = 0;
      end
      if (eng_en) begin
        en_cyc++;
        if (!en_seen) begin
          en_seen   = 1;
          seen_mode = eng_mode;
          seen_a    = eng_a;
          seen_b    = eng_b;
        end
      end
      if (bus.o_rsp_valid && !rsp_seen) begin
        rsp_seen = 1;
        rsp_cyc  = cyc;
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        rsp_cnt++;
        if (expq.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_rsp: got id %0d, none expected", bus.o_rsp_id);
        end else begin
          exp_t e;
          e = expq.pop_front();
          checkOutput("rsp_id", 64'(bus.o_rsp_id), 64'(e.id));
          checkOutput("rsp_c", 64'(bus.o_rsp_c), 64'(e.c));
          checkOutput("rsp_err", 64'(bus.o_rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    bit got;
    @(posedge clk); #1;
    lat    = v.lat;
    cur_op = v.op;
    bus.i_req_op[v.id]             = v.op;
    bus.i_req_mode[v.id]           = v.mode;
    bus.i_req_a[v.id*WIDTH +: WIDTH] = v.a;
    bus.i_req_b[v.id*WIDTH +: WIDTH] = v.b;
    bus.i_req_valid[v.id]          = 1'b1;
    expq.push_back('{v.id, v.c, v.err});
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.o_req_ready[v.id]) got = 1;
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL grant_wait: req %0d got no ready, required ready", v.id);
    end
    @(posedge clk); #1;
    bus.i_req_valid[v.id] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_cnt < target; i++) @(negedge clk);
    if (rsp_cnt < target) begin
      checks++;
      $display("[TB] FAIL rsp_wait: got %0d responses, required %0d", rsp_cnt, target);
    end
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 200 && acc_cnt < target; i++) @(negedge clk);
    if (acc_cnt < target) begin
      checks++;
      $display("[TB] FAIL acc_wait: got %0d accepts, required %0d", acc_cnt, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ready"}, 64'(bus.o_req_ready), 64'h0);
    checkOutput({tag, "_eng_en"}, 64'(eng_en), 64'h0);
    checkOutput({tag, "_eng_mab"}, {31'h0, eng_mode, eng_a, eng_b}, 64'h0);
    checkOutput({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'h0);
    checkOutput({tag, "_rsp_fields"}, {45'h0, bus.o_rsp_err, bus.o_rsp_id, bus.o_rsp_c}, 64'h0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_rsp, base_acc, bad;
    logic [15:0] snap_c;

    tbl[0] = '{0, 1'b1, 1'b0, 16'd7,  16'd9,  1,  16'd3,  1'b0, 1};
    tbl[1] = '{1, 1'b0, 1'b1, 16'd3,  16'd9,  2,  16'd7,  1'b0, 2};
    tbl[2] = '{2, 1'b1, 1'b1, 16'd12, 16'd12, 3,  16'd11, 1'b0, 3};
    tbl[3] = '{3, 1'b0, 1'b0, 16'd9,  16'd3,  1,  16'd6,  1'b0, 1};
    tbl[4] = '{0, 1'b1, 1'b0, 16'd1,  16'd2,  0,  16'd0,  1'b1, 16};
    tbl[5] = '{1, 1'b1, 1'b1, 16'd4,  16'd4,  1,  16'd8,  1'b0, 1};
    tbl[6] = '{3, 1'b1, 1'b0, 16'd6,  16'd6,  16, 16'd12, 1'b0, 16};
    tbl[7] = '{2, 1'b0, 1'b1, 16'd2,  16'd5,  17, 16'd0,  1'b1, 16};

    p_val           = 16'(P);
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_mode  = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    checkOutput("eng_p", 64'(eng_p), 64'(P));

    // table-driven single requests
    foreach (tbl[n]) begin
      base_rsp = rsp_cnt;
      applyStimulus(tbl[n]);
      wait_rsp(base_rsp + 1);
      checkOutput($sformatf("en_cycles[%0d]", n), 64'(en_cyc), 64'(tbl[n].en_cyc));
      checkOutput($sformatf("latency[%0d]", n), 64'(rsp_cyc - acc_cyc), 64'(tbl[n].en_cyc + 1));
      checkOutput($sformatf("eng_ops[%0d]", n), {31'h0, seen_mode, seen_a, seen_b},
                  {31'h0, tbl[n].mode, tbl[n].a, tbl[n].b});
    end

    // backpressure: response held, no new grant while req0 waits
    repeat (3) @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
    base_rsp = rsp_cnt;
    base_acc = acc_cnt;
    applyStimulus('{2, 1'b1, 1'b0, 16'd4, 16'd5, 1, 16'd9, 1'b0, 1});
    bus.i_req_op[0]            = 1'b1;
    bus.i_req_a[0 +: WIDTH]    = 16'd1;
    bus.i_req_b[0 +: WIDTH]    = 16'd1;
    bus.i_req_valid[0]         = 1'b1;
    expq.push_back('{0, 16'd2, 1'b0});
    for (int i = 0; i < 20 && !bus.o_rsp_valid; i++) @(negedge clk);
    snap_c = bus.o_rsp_c;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.o_rsp_valid || bus.o_rsp_c !== snap_c || bus.o_rsp_id !== 2'd2 ||
          eng_en || bus.o_req_ready !== '0) bad++;
    end
    checkOutput("bp_stable", 64'(bad), 64'h0);
    checkOutput("bp_held_c", 64'(snap_c), 64'd9);
    checkOutput("bp_no_accept", 64'(acc_cnt - base_acc), 64'd1);
    @(posedge clk); #1 bus.i_rsp_ready = 1'b1;
    wait_acc(base_acc + 2);
    @(posedge clk); #1 bus.i_req_valid[0] = 1'b0;
    wait_rsp(base_rsp + 2);

    // reset during RUN with a slow engine
    repeat (3) @(posedge clk);
    #1;
    lat = 10;
    base_rsp = rsp_cnt;
    bus.i_req_valid[1] = 1'b1;
    for (int i = 0; i < 20 && !bus.o_req_ready[1]; i++) @(negedge clk);
    @(posedge clk); #1 bus.i_req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_rsp_after_reset", 64'(rsp_cnt - base_rsp), 64'h0);

    // all requesters valid: grant order 0,1,2,3,0
    @(posedge clk); #1;
    lat    = 2;
    cur_op = 1'b1;
    base_rsp = rsp_cnt;
    base_acc = acc_cnt;
    for (int k = 0; k < NREQ; k++) begin
      bus.i_req_op[k]               = 1'b1;
      bus.i_req_a[k*WIDTH +: WIDTH] = 16'(k + 2);
      bus.i_req_b[k*WIDTH +: WIDTH] = 16'd10;
    end
    bus.i_req_valid = '1;
    for (int n = 0; n < 5; n++) expq.push_back('{n % NREQ, 16'((n % NREQ + 12) % P), 1'b0});
    @(negedge clk);
    checkOutput("first_grant_after_reset", 64'(bus.o_req_ready), 64'h1);
    wait_acc(base_acc + 5);
    @(posedge clk); #1 bus.i_req_valid = '0;
    wait_rsp(base_rsp + 5);

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 64'(expq.size()), 64'h0);
    checkOutput("idle_at_end", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
